// File: rtl/vga_pixel_fetch.sv
// Pixel fetch stage: pulls RGB565 words from the SDRAM read FIFO in step with the
// display timing and presents RGB888 pixels with the timing delayed to match.
module vga_pixel_fetch #(
    parameter int          H_ACTIVE      = 800,
    parameter logic [23:0] UNDERFLOW_RGB = 24'h000000
) (
    input  logic        pixel_clock,
    input  logic        reset_n,
    input  logic        in_hs,
    input  logic        in_vs,
    input  logic        in_blank,
    input  logic        in_de,
    output logic        fifo_rd_req,
    input  logic [15:0] fifo_rd_data,
    input  logic        fifo_empty,
    output logic        frame_sync,
    output logic        out_hs,
    output logic        out_vs,
    output logic        out_blank,
    output logic        out_de,
    output logic [23:0] out_rgb,
    output logic [15:0] underflow_cnt,
    output logic        frame_underflow,
    output logic        line_err
);

    localparam logic [1:0] SYNC_WAIT   = 2'd0;
    localparam logic [1:0] FRAME_START = 2'd1;
    localparam logic [1:0] ACTIVE      = 2'd2;

    // Wide enough to hold a count above H_ACTIVE so an over-long line still mismatches.
    localparam int                    LINE_CNT_W  = $clog2(H_ACTIVE + 2);
    localparam logic [LINE_CNT_W-1:0] LINE_TARGET = LINE_CNT_W'(H_ACTIVE);

    logic [1:0]            state;
    logic                  vs_d;
    logic                  vs_armed;
    logic                  vs_rise;
    logic                  is_active;
    logic                  underflow;
    logic                  de_fall;
    logic                  s1_hs;
    logic                  s1_vs;
    logic                  s1_blank;
    logic                  s1_de;
    logic                  s1_rd;
    logic                  s1_uf;
    logic [LINE_CNT_W-1:0] line_cnt;

    // vs_armed ensures a level that is already high at reset release is not taken as an edge.
    assign vs_rise     = in_vs & ~vs_d & vs_armed;
    assign is_active   = (state == ACTIVE);
    assign fifo_rd_req = in_de & is_active & ~fifo_empty & ~vs_rise;
    assign underflow   = in_de & is_active & (fifo_empty | vs_rise);
    assign frame_sync  = (state == FRAME_START);
    assign de_fall     = s1_de & ~in_de & is_active;

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= SYNC_WAIT;
            vs_d     <= 1'b0;
            vs_armed <= 1'b0;
        end else begin
            vs_d     <= in_vs;
            vs_armed <= vs_armed | ~in_vs;
            case (state)
                SYNC_WAIT:   if (vs_rise) state <= FRAME_START;
                FRAME_START: state <= ACTIVE;
                ACTIVE:      if (vs_rise) state <= FRAME_START;
                default:     state <= SYNC_WAIT;
            endcase
        end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_hs     <= 1'b0;
            s1_vs     <= 1'b0;
            s1_blank  <= 1'b0;
            s1_de     <= 1'b0;
            s1_rd     <= 1'b0;
            s1_uf     <= 1'b0;
            out_hs    <= 1'b0;
            out_vs    <= 1'b0;
            out_blank <= 1'b0;
            out_de    <= 1'b0;
            out_rgb   <= 24'h000000;
        end else begin
            s1_hs     <= in_hs;
            s1_vs     <= in_vs;
            s1_blank  <= in_blank;
            s1_de     <= in_de;
            s1_rd     <= fifo_rd_req;
            s1_uf     <= underflow;
            out_hs    <= s1_hs;
            out_vs    <= s1_vs;
            out_blank <= s1_blank;
            out_de    <= s1_de;
            // The FIFO word arrives one cycle after the strobe, i.e. alongside stage 1.
            if (s1_rd)
                out_rgb <= {fifo_rd_data[15:11], fifo_rd_data[15:13],
                            fifo_rd_data[10:5],  fifo_rd_data[10:9],
                            fifo_rd_data[4:0],   fifo_rd_data[4:2]};
            else if (s1_uf)
                out_rgb <= UNDERFLOW_RGB;
            else
                out_rgb <= 24'h000000;
        end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            underflow_cnt   <= 16'h0000;
            frame_underflow <= 1'b0;
            line_err        <= 1'b0;
            line_cnt        <= '0;
        end else begin
            if (underflow && underflow_cnt != 16'hFFFF)
                underflow_cnt <= underflow_cnt + 16'd1;

            if (underflow)
                frame_underflow <= 1'b1;
            else if (frame_sync)
                frame_underflow <= 1'b0;

            if (de_fall && line_cnt != LINE_TARGET)
                line_err <= 1'b1;
            else if (frame_sync)
                line_err <= 1'b0;

            // Saturate rather than wrap so a runaway line can never alias to a good count.
            if (frame_sync || de_fall)
                line_cnt <= '0;
            else if (in_de && is_active && line_cnt != '1)
                line_cnt <= line_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Randomised bench for vga_pixel_fetch, checked cycle by cycle against a
// history-based reference model of the frame/line rules.
module tb_vga_pixel_fetch;

    localparam int          H           = 16;
    localparam int          LINE_LEN    = 24;
    localparam int          FRAME_LINES = 9;
    localparam int          ACT_LINES   = 6;
    localparam int          VS_LINE     = 7;
    localparam logic [23:0] UF_RGB      = 24'h5A3C96;
    localparam int          MAXC        = 80000;
    localparam int          NONE        = -100;

    logic        pixel_clock = 1'b0;
    logic        reset_n     = 1'b0;
    logic        in_hs = 1'b0, in_vs = 1'b0, in_blank = 1'b0, in_de = 1'b0;
    logic        fifo_empty  = 1'b0;
    logic [15:0] fifo_rd_data = 16'h0000;
    logic        fifo_rd_req, frame_sync;
    logic        out_hs, out_vs, out_blank, out_de;
    logic [23:0] out_rgb;
    logic [15:0] underflow_cnt;
    logic        frame_underflow, line_err;

    vga_pixel_fetch #(.H_ACTIVE(H), .UNDERFLOW_RGB(UF_RGB)) dut (
        .pixel_clock(pixel_clock), .reset_n(reset_n),
        .in_hs(in_hs), .in_vs(in_vs), .in_blank(in_blank), .in_de(in_de),
        .fifo_rd_req(fifo_rd_req), .fifo_rd_data(fifo_rd_data), .fifo_empty(fifo_empty),
        .frame_sync(frame_sync),
        .out_hs(out_hs), .out_vs(out_vs), .out_blank(out_blank), .out_de(out_de),
        .out_rgb(out_rgb), .underflow_cnt(underflow_cnt),
        .frame_underflow(frame_underflow), .line_err(line_err)
    );

    always #5 pixel_clock = ~pixel_clock;

    int vec_count  = 0;
    int miss_count = 0;

    // Per-cycle input history; kind 1 = pixel read, 2 = underflow pixel, 0 = neither.
    logic [3:0]  hist_tim  [MAXC];
    logic [1:0]  hist_kind [MAXC];
    logic [15:0] hist_data [MAXC];
    int cyc = 2;
    int rel_cyc = 2;
    bit pending_release = 1'b1;
    int last_rise = NONE;
    int m_uf_cnt = 0;
    bit m_frame_uf = 1'b0;
    bit m_line_err = 1'b0;
    int m_run = 0;

    int hcnt = 0, vcnt = 0, cur_trim = 0;
    bit short_req = 1'b0, burst_req = 1'b0, const_mode = 1'b0;
    int burst_left = 0, empty_pct = 0;
    logic [15:0] const_word = 16'hF800;
    logic [15:0] picks [4] = '{16'h07E0, 16'h001F, 16'hFFFF, 16'hF800};

    function automatic logic [23:0] rgb888(input logic [15:0] w);
        int r, g, b;
        r = (w >> 11) & 31;
        g = (w >> 5) & 63;
        b = w & 31;
        return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vec_count++;
        if (actual !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic hs, input logic vs, input logic blank, input logic de,
                                 input logic empty, input logic [15:0] data);
        int t;
        logic [3:0]  tim2;
        logic [1:0]  k2;
        logic [23:0] exp_rgb;
        logic        exp_fs, exp_act, exp_rise, exp_rd, exp_uf, de_fall;
        @(negedge pixel_clock);
        t = cyc;
        if (t >= MAXC - 1) begin
            $display("[TB] FAIL cycle_budget: got %0d cycles, limit %0d", t, MAXC);
            $fatal(1, "[TB] cycle budget exhausted");
        end
        tim2 = 4'b0;
        k2 = 2'd0;
        exp_rgb = 24'h0;
        if (t - 2 >= rel_cyc) begin
            tim2 = hist_tim[t-2];
            k2   = hist_kind[t-2];
            if (k2 == 2'd1) exp_rgb = rgb888(hist_data[t-1]);
            else if (k2 == 2'd2) exp_rgb = UF_RGB;
        end
        checkOutput("out_timing", {28'h0, out_hs, out_vs, out_blank, out_de}, {28'h0, tim2});
        checkOutput("out_rgb", {8'h0, out_rgb}, {8'h0, exp_rgb});
        checkOutput("underflow_cnt", {16'h0, underflow_cnt}, m_uf_cnt);
        checkOutput("frame_underflow", {31'h0, frame_underflow}, {31'h0, m_frame_uf});
        checkOutput("line_err", {31'h0, line_err}, {31'h0, m_line_err});

        in_hs = hs; in_vs = vs; in_blank = blank; in_de = de;
        fifo_empty = empty; fifo_rd_data = data;
        if (pending_release) begin
            reset_n = 1'b1;
            pending_release = 1'b0;
        end
        #1;
        // A frame start is the cycle right after a rising edge; active once any frame has started.
        exp_fs   = (last_rise == t - 1);
        exp_act  = (last_rise != NONE) && !exp_fs;
        exp_rise = vs && (t - 1 >= rel_cyc) && !hist_tim[t-1][2];
        exp_rd   = de && exp_act && !empty && !exp_rise;
        exp_uf   = de && exp_act && (empty || exp_rise);
        checkOutput("frame_sync", {31'h0, frame_sync}, {31'h0, exp_fs});
        checkOutput("fifo_rd_req", {31'h0, fifo_rd_req}, {31'h0, exp_rd});

        hist_tim[t]  = {hs, vs, blank, de};
        hist_kind[t] = exp_rd ? 2'd1 : (exp_uf ? 2'd2 : 2'd0);
        hist_data[t] = data;
        if (exp_uf && m_uf_cnt < 65535) m_uf_cnt++;
        if (exp_uf) m_frame_uf = 1'b1;
        else if (exp_fs) m_frame_uf = 1'b0;
        de_fall = exp_act && !de && (t - 1 >= rel_cyc) && hist_tim[t-1][0];
        if (de_fall && m_run != H) m_line_err = 1'b1;
        else if (exp_fs) m_line_err = 1'b0;
        if (de_fall || exp_fs) m_run = 0;
        else if (de && exp_act) m_run++;
        if (exp_rise) last_rise = t;
        @(posedge pixel_clock);
        cyc++;
    endtask

    task automatic genCycle();
        logic de, empty;
        logic [15:0] data;
        if (hcnt == 0) begin
            cur_trim = (short_req && vcnt < ACT_LINES) ? 1 : 0;
            if (cur_trim == 1) short_req = 1'b0;
        end
        de = (hcnt < H - cur_trim) && (vcnt < ACT_LINES);
        if (burst_req && de && hcnt == 3) begin
            burst_left = 10;
            burst_req  = 1'b0;
        end
        if (burst_left > 0 && de) begin
            empty = 1'b1;
            burst_left--;
        end else begin
            empty = ($urandom_range(99) < empty_pct);
        end
        if (const_mode) data = const_word;
        else if ($urandom_range(3) == 0) data = picks[$urandom_range(3)];
        else data = 16'($urandom);
        applyStimulus(hcnt >= 18 && hcnt < 20, vcnt == VS_LINE, !de, de, empty, data);
        hcnt++;
        if (hcnt == LINE_LEN) begin
            hcnt = 0;
            vcnt = (vcnt + 1) % FRAME_LINES;
        end
    endtask

    task automatic doReset();
        @(negedge pixel_clock);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("reset_flags", {24'h0, fifo_rd_req, frame_sync, out_hs, out_vs, out_blank,
                                    out_de, frame_underflow, line_err}, 32'h0);
        checkOutput("reset_rgb", {8'h0, out_rgb}, 32'h0);
        checkOutput("reset_uf_cnt", {16'h0, underflow_cnt}, 32'h0);
        repeat (2) @(negedge pixel_clock);
        checkOutput("reset_hold_req", {31'h0, fifo_rd_req}, 32'h0);
        last_rise = NONE;
        m_uf_cnt = 0;
        m_frame_uf = 1'b0;
        m_line_err = 1'b0;
        m_run = 0;
        rel_cyc = cyc;
        pending_release = 1'b1;
    endtask

    initial begin
        #12;
        checkOutput("init_flags", {24'h0, fifo_rd_req, frame_sync, out_hs, out_vs, out_blank,
                                   out_de, frame_underflow, line_err}, 32'h0);
        checkOutput("init_rgb", {8'h0, out_rgb}, 32'h0);
        checkOutput("init_uf_cnt", {16'h0, underflow_cnt}, 32'h0);

        // vs already high at release: the first frame must wait for a genuine low-to-high edge.
        hcnt = 0;
        vcnt = VS_LINE;
        const_mode = 1'b1;
        repeat (4 * FRAME_LINES * LINE_LEN) genCycle();
        checkOutput("clean_uf_cnt", {16'h0, underflow_cnt}, 32'h0);
        checkOutput("clean_line_err", {31'h0, line_err}, 32'h0);

        const_mode = 1'b0;
        repeat (2 * FRAME_LINES * LINE_LEN) genCycle();
        burst_req = 1'b1;
        repeat (FRAME_LINES * LINE_LEN) genCycle();
        short_req = 1'b1;
        repeat (FRAME_LINES * LINE_LEN) genCycle();
        empty_pct = 10;
        repeat (3 * FRAME_LINES * LINE_LEN) genCycle();

        // One very long starved run drives the underflow counter into saturation.
        for (int i = 0; i < 65540; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'($urandom));
        checkOutput("uf_saturated", {16'h0, underflow_cnt}, 32'h0000FFFF);

        empty_pct = 0;
        repeat (FRAME_LINES * LINE_LEN) genCycle();
        while (!(vcnt == 2 && hcnt == 8)) genCycle();
        doReset();
        empty_pct = 5;
        repeat (2 * FRAME_LINES * LINE_LEN) genCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
        $finish;
    end

endmodule

// File: doc/vga_pixel_fetch.md
VGA_PIXEL_FETCH -- requirements
Module: vga_pixel_fetch

Interface
REQ-001 The block SHALL take parameter H_ACTIVE, 800, active pixels per line (in_de run length).
REQ-002 The block SHALL take parameter UNDERFLOW_RGB, 24'h000000, colour driven for a pixel with no FIFO data.
REQ-003 The block SHALL have port pixel_clock  input  1  pixel clock, all logic on its rising edge.
REQ-004 The block SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have ports in_hs, in_vs, in_blank, in_de  input  1 each  active-high timing from the timing generator.
REQ-006 The block SHALL have port fifo_rd_req  output  1  read strobe to the SDRAM read FIFO.
REQ-007 The block SHALL have port fifo_rd_data  input  16  RGB565 word, valid the cycle after fifo_rd_req.
REQ-008 The block SHALL have port fifo_empty  input  1  FIFO holds no word.
REQ-009 The block SHALL have port frame_sync  output  1  one-cycle pulse telling the SDRAM reader to restart at frame address 0.
REQ-010 The block SHALL have ports out_hs, out_vs, out_blank, out_de  output  1 each  timing delayed to match out_rgb.
REQ-011 The block SHALL have port out_rgb  output  24  RGB888 pixel {R,G,B}.
REQ-012 The block SHALL have port underflow_cnt  output  16  cumulative underflow pixels, saturating.
REQ-013 The block SHALL have ports frame_underflow, line_err  output  1 each  sticky per-frame error flags.

Function
REQ-014 The block SHALL implement states SYNC_WAIT, FRAME_START, ACTIVE.
REQ-015 vs_rise SHALL be in_vs high this cycle and low the previous cycle (one input register).
REQ-016 SYNC_WAIT -> FRAME_START on vs_rise; ACTIVE -> FRAME_START on vs_rise; FRAME_START -> ACTIVE unconditionally after one cycle.
REQ-017 frame_sync SHALL be high exactly in FRAME_START cycles.
REQ-018 fifo_rd_req SHALL be combinational: in_de AND state==ACTIVE AND NOT fifo_empty AND NOT vs_rise.
REQ-019 A pixel is "underflow" when in_de AND state==ACTIVE AND (fifo_empty OR vs_rise).
REQ-020 out_hs/out_vs/out_blank/out_de SHALL equal in_hs/in_vs/in_blank/in_de delayed exactly 2 cycles.
REQ-021 out_rgb SHALL be registered in stage 2 from the stage-1 sample: read pixel -> converted fifo_rd_data; underflow pixel -> UNDERFLOW_RGB; all else (in_de low or state != ACTIVE) -> 24'h000000.
REQ-022 Conversion SHALL be R={d[15:11],d[15:13]}, G={d[10:5],d[10:9]}, B={d[4:0],d[4:2]}.
REQ-023 underflow_cnt SHALL increment by 1 per underflow pixel, hold at 16'hFFFF, never clear except reset.
REQ-024 frame_underflow SHALL set on any underflow pixel and clear in FRAME_START; set wins if both coincide.
REQ-025 A per-line counter SHALL count in_de-high cycles in ACTIVE; on in_de falling edge count != H_ACTIVE sets line_err; counter clears at each falling edge and in FRAME_START.
REQ-026 line_err SHALL clear in FRAME_START; set wins on coincidence.
REQ-027 In SYNC_WAIT no read SHALL be issued, errors SHALL not count, and timing SHALL still pass through delayed.

Reset
REQ-028 On reset_n low all outputs, pipeline registers, counters and flags SHALL be 0 and state SHALL be SYNC_WAIT, asynchronously.
REQ-029 After reset release, first frame_sync SHALL occur only after a full vs_rise (in_vs low then high) is seen.
REQ-030 Reset asserted mid-line SHALL abort reads immediately (fifo_rd_req 0 same cycle).

Verification
REQ-031 Reset, then 3 frames at 800x600 with FIFO always non-empty holding 16'hF800 -> one frame_sync per vs_rise, out_rgb 24'hFF0000 during out_de, underflow_cnt 0, line_err 0.
REQ-032 Word 16'h07E0 read at cycle T -> out_rgb 24'h00FF00 at T+2 aligned with out_de; word 16'h001F -> 24'h0000FF; 16'hFFFF -> 24'hFFFFFF.
REQ-033 fifo_empty forced high for 10 in_de cycles mid-line -> no fifo_rd_req those cycles, 10 pixels of UNDERFLOW_RGB, underflow_cnt +10, frame_underflow 1 until next frame_sync.
REQ-034 in_de run of 799 cycles -> line_err 1 after falling edge, cleared in following FRAME_START.
REQ-035 Before any vs_rise after reset, in_de toggling with FIFO non-empty -> fifo_rd_req stays 0, out_rgb 0.
REQ-036 Preload underflow_cnt to 16'hFFFE via 2+ underflows -> stays 16'hFFFF; reset_n pulse mid-line -> all outputs 0, state SYNC_WAIT.
